// File: rtl/mem_arb_pkg.sv
// Shared definitions for the I/D memory arbiter: pend-state encoding, default sizing, port IDs.
// Optional starvation guard is enabled by defining MEM_ARB_STARVE_GUARD_EN.
package mem_arb_pkg;

    localparam int ADDR_W_DEF       = 8;
    localparam int STARVE_LIMIT_DEF = 4;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] I_PEND = 2'd1;
    localparam logic [1:0] D_PEND = 2'd2;

    // Port identity, also used by the core's LSU to tag requests.
    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_id_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive denied fetch cycles; raises starve_force at the limit.
// Only instantiated when MEM_ARB_STARVE_GUARD_EN is defined.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_req,
    input  logic i_gnt,
    input  logic i_flush,
    output logic starve_force
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (i_gnt) begin
            count <= '0;
        end else if (i_req && !i_flush && count != LIMIT_C) begin
            count <= count + 1'b1;
        end
    end

    assign starve_force = (count == LIMIT_C);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch (I) and load/store (D) ports onto one single-port 1-cycle-latency RAM.
// Define MEM_ARB_STARVE_GUARD_EN to let a starved fetch win over D once per STARVE_LIMIT denials.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              i_flush,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_rdata
);

    logic       starve_force;
    logic       i_wins;
    port_id_e   owner;
    logic [1:0] pend;
    logic [1:0] pend_next;
    logic       unused_addr;

`ifdef MEM_ARB_STARVE_GUARD_EN
    mem_arb_starve_ctr #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk          (clk),
        .reset        (reset),
        .i_req        (i_req),
        .i_gnt        (i_gnt),
        .i_flush      (i_flush),
        .starve_force (starve_force)
    );
`else
    // Guard compiled out: the limit has no effect and D always wins.
    assign starve_force = (STARVE_LIMIT < 0);
`endif

    // A forced fetch only takes the slot if it could actually be granted.
    assign i_wins = starve_force & i_req & ~i_flush;

    assign d_gnt  = d_req & ~reset & ~i_wins;
    assign i_gnt  = i_req & ~i_flush & ~reset & (~d_req | i_wins);
    assign mem_en = i_gnt | d_gnt;
    assign owner  = d_gnt ? PORT_D : PORT_I;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (mem_en) begin
            case (owner)
                PORT_D: begin
                    mem_we    = d_we;
                    mem_addr  = d_addr[ADDR_W+1:2];
                    mem_wdata = d_wdata;
                    mem_wstrb = d_wstrb;
                end
                default: begin
                    mem_addr  = i_addr[ADDR_W+1:2];
                end
            endcase
        end
    end

    always_comb begin
        pend_next = IDLE;
        if (i_gnt) begin
            pend_next = I_PEND;
        end else if (d_gnt && !d_we) begin
            pend_next = D_PEND;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= IDLE;
        end else begin
            pend <= pend_next;
        end
    end

    // A flush arriving with a due fetch response squashes it.
    assign i_rvalid = (pend == I_PEND) & ~i_flush;
    assign d_rvalid = (pend == D_PEND);
    assign i_rdata  = i_rvalid ? mem_rdata : 32'h0;
    assign d_rdata  = d_rvalid ? mem_rdata : 32'h0;

    // Byte offset and bits above the RAM size are ignored; high bits alias.
    assign unused_addr = ^{i_addr[31:ADDR_W+2], i_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]};

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural RAM, reference memory image and response scoreboard.
// Exercises the starvation guard when MEM_ARB_STARVE_GUARD_EN is defined, plain D priority otherwise.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic        i_flush = 1'b0;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'h0;
    logic [31:0] d_wdata = 32'h0;
    logic [3:0]  d_wstrb = 4'h0;
    logic [31:0] mem_rdata = 32'h0;

    logic        i_gnt, i_rvalid, d_gnt, d_rvalid;
    logic [31:0] i_rdata, d_rdata;
    logic        mem_en, mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [15:0] bus;

    logic [31:0] ram     [256];
    logic [31:0] ref_mem [256];

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .i_flush   (i_flush),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    assign bus = {i_gnt, d_gnt, mem_en, mem_we, mem_wstrb, mem_addr};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wstrb[b]) ram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    // Response scoreboard: every rvalid must match the oldest expected response, data and cycle.
    always @(negedge clk) begin
        exp_t e;
        checks++;
        if (i_rvalid) begin
            if (iq.size() == 0) begin
                errors++;
                $display("FAIL i_resp_unexpected: i_rvalid=1 i_rdata=%h at cycle %0d, no fetch due", i_rdata, cyc);
            end else begin
                e = iq.pop_front();
                if (i_rdata !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL i_resp: got %h at cycle %0d, want %h at cycle %0d", i_rdata, cyc, e.data, e.cyc);
                end
            end
        end else if (i_rdata !== 32'h0) begin
            errors++;
            $display("FAIL i_rdata_idle: got %h, want 00000000", i_rdata);
        end
        checks++;
        if (d_rvalid) begin
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL d_resp_unexpected: d_rvalid=1 d_rdata=%h at cycle %0d, no load due", d_rdata, cyc);
            end else begin
                e = dq.pop_front();
                if (d_rdata !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL d_resp: got %h at cycle %0d, want %h at cycle %0d", d_rdata, cyc, e.data, e.cyc);
                end
            end
        end else if (d_rdata !== 32'h0) begin
            errors++;
            $display("FAIL d_rdata_idle: got %h, want 00000000", d_rdata);
        end
    end

    function automatic logic [15:0] bus_exp(input logic ig, input logic dg, input logic we,
                                            input logic [3:0] strb, input logic [7:0] addr);
        return {ig, dg, ig | dg, we, strb, addr};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        i_req  = 1'b1;
        i_addr = 32'h8;
        d_req  = 1'b1;
        d_addr = 32'h10;
        #2;
        checks++;
        if (bus !== 16'h0) begin
            errors++;
            $display("FAIL reset_bus: got %b, want %b", bus, 16'h0);
        end
        checks++;
        if ({i_rvalid, d_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_rvalid: got %b, want 00", {i_rvalid, d_rvalid});
        end
        tick();
        tick();
        reset = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic test_fetch();
        tick();
        i_req  = 1'b1;
        i_addr = 32'h0000_0008;
        @(negedge clk);
        checks++;
        if (bus !== bus_exp(1'b1, 1'b0, 1'b0, 4'h0, 8'd2)) begin
            errors++;
            $display("FAIL fetch_grant: got %b, want %b", bus, bus_exp(1'b1, 1'b0, 1'b0, 4'h0, 8'd2));
        end
        iq.push_back('{ref_mem[2], cyc + 1});
        tick();
        i_req = 1'b0;
    endtask

    task automatic test_collision();
        tick();
        i_req  = 1'b1;
        i_addr = 32'h0000_000C;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0010;
        @(negedge clk);
        checks++;
        if (bus !== bus_exp(1'b0, 1'b1, 1'b0, 4'h0, 8'd4)) begin
            errors++;
            $display("FAIL collide_d_first: got %b, want %b", bus, bus_exp(1'b0, 1'b1, 1'b0, 4'h0, 8'd4));
        end
        dq.push_back('{ref_mem[4], cyc + 1});
        tick();
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus !== bus_exp(1'b1, 1'b0, 1'b0, 4'h0, 8'd3)) begin
            errors++;
            $display("FAIL collide_i_retry: got %b, want %b", bus, bus_exp(1'b1, 1'b0, 1'b0, 4'h0, 8'd3));
        end
        iq.push_back('{ref_mem[3], cyc + 1});
        tick();
        i_req = 1'b0;
    endtask

    task automatic test_store_load();
        tick();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h0000_0020;
        d_wdata = 32'hDEAD_BEEF;
        d_wstrb = 4'b0011;
        @(negedge clk);
        checks++;
        if (bus !== bus_exp(1'b0, 1'b1, 1'b1, 4'b0011, 8'd8) || mem_wdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL store_drive: got %b/%h, want %b/deadbeef", bus, mem_wdata,
                     bus_exp(1'b0, 1'b1, 1'b1, 4'b0011, 8'd8));
        end
        for (int b = 0; b < 4; b++) begin
            if (d_wstrb[b]) ref_mem[8][8*b +: 8] = d_wdata[8*b +: 8];
        end
        tick();
        d_we = 1'b0;
        @(negedge clk);
        checks++;
        if (bus !== bus_exp(1'b0, 1'b1, 1'b0, 4'b0011, 8'd8)) begin
            errors++;
            $display("FAIL load_after_store: got %b, want %b", bus, bus_exp(1'b0, 1'b1, 1'b0, 4'b0011, 8'd8));
        end
        dq.push_back('{ref_mem[8], cyc + 1});
        tick();
        d_req   = 1'b0;
        d_wstrb = 4'h0;
    endtask

    task automatic test_flush();
        tick();
        i_req  = 1'b1;
        i_addr = 32'h0000_0008;
        @(negedge clk);
        checks++;
        if (bus !== bus_exp(1'b1, 1'b0, 1'b0, 4'h0, 8'd2)) begin
            errors++;
            $display("FAIL flush_pre_grant: got %b, want %b", bus, bus_exp(1'b1, 1'b0, 1'b0, 4'h0, 8'd2));
        end
        tick();
        i_addr  = 32'h0000_0040;
        i_flush = 1'b1;
        @(negedge clk);
        checks++;
        if (bus !== 16'h0 || i_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL flush_squash: got bus=%b i_rvalid=%b, want bus=%b i_rvalid=0", bus, i_rvalid, 16'h0);
        end
        tick();
        i_flush = 1'b0;
        @(negedge clk);
        checks++;
        if (bus !== bus_exp(1'b1, 1'b0, 1'b0, 4'h0, 8'd16)) begin
            errors++;
            $display("FAIL flush_refetch: got %b, want %b", bus, bus_exp(1'b1, 1'b0, 1'b0, 4'h0, 8'd16));
        end
        iq.push_back('{ref_mem[16], cyc + 1});
        tick();
        i_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        tick();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0010;
        @(negedge clk);
        checks++;
        if (bus !== bus_exp(1'b0, 1'b1, 1'b0, 4'h0, 8'd4)) begin
            errors++;
            $display("FAIL rst_mid_grant: got %b, want %b", bus, bus_exp(1'b0, 1'b1, 1'b0, 4'h0, 8'd4));
        end
        tick();
        reset  = 1'b1;
        i_req  = 1'b1;
        i_addr = 32'h0000_0008;
        #1;
        checks++;
        if (bus !== 16'h0 || d_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_drop: got bus=%b d_rvalid=%b, want bus=%b d_rvalid=0", bus, d_rvalid, 16'h0);
        end
        tick();
        reset = 1'b0;
        d_req = 1'b0;
        i_req = 1'b0;
        tick();
        i_req  = 1'b1;
        i_addr = 32'h0000_000C;
        @(negedge clk);
        checks++;
        if (bus !== bus_exp(1'b1, 1'b0, 1'b0, 4'h0, 8'd3)) begin
            errors++;
            $display("FAIL rst_mid_resume: got %b, want %b", bus, bus_exp(1'b1, 1'b0, 1'b0, 4'h0, 8'd3));
        end
        iq.push_back('{ref_mem[3], cyc + 1});
        tick();
        i_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        for (int k = 0; k < 3; k++) begin
            tick();
            d_req  = 1'b1;
            d_we   = 1'b0;
            d_addr = 32'h10 + 32'(4 * k);
            if (k == 2) d_addr = d_addr | 32'hFFFF_F000;
            w = 8'(4 + k);
            @(negedge clk);
            checks++;
            if (bus !== bus_exp(1'b0, 1'b1, 1'b0, 4'h0, w)) begin
                errors++;
                $display("FAIL b2b_load%0d: got %b, want %b", k, bus, bus_exp(1'b0, 1'b1, 1'b0, 4'h0, w));
            end
            dq.push_back('{ref_mem[w], cyc + 1});
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            d_req  = 1'b0;
            i_req  = 1'b1;
            i_addr = (k == 0) ? 32'h0000_0408 : 32'h0000_000C;
            w = (k == 0) ? 8'd2 : 8'd3;
            @(negedge clk);
            checks++;
            if (bus !== bus_exp(1'b1, 1'b0, 1'b0, 4'h0, w)) begin
                errors++;
                $display("FAIL b2b_fetch%0d: got %b, want %b", k, bus, bus_exp(1'b1, 1'b0, 1'b0, 4'h0, w));
            end
            iq.push_back('{ref_mem[w], cyc + 1});
        end
        tick();
        i_req = 1'b0;
    endtask

`ifdef MEM_ARB_STARVE_GUARD_EN
    task automatic test_starve();
        logic exp_i;
        tick();
        i_req  = 1'b1;
        i_addr = 32'h0000_0008;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0010;
        for (int k = 0; k < 7; k++) begin
            exp_i = (k == 4);
            @(negedge clk);
            checks++;
            if (exp_i) begin
                if (bus !== bus_exp(1'b1, 1'b0, 1'b0, 4'h0, 8'd2)) begin
                    errors++;
                    $display("FAIL starve_cycle%0d: got %b, want %b", k, bus, bus_exp(1'b1, 1'b0, 1'b0, 4'h0, 8'd2));
                end
                iq.push_back('{ref_mem[2], cyc + 1});
            end else begin
                if (bus !== bus_exp(1'b0, 1'b1, 1'b0, 4'h0, 8'd4)) begin
                    errors++;
                    $display("FAIL starve_cycle%0d: got %b, want %b", k, bus, bus_exp(1'b0, 1'b1, 1'b0, 4'h0, 8'd4));
                end
                dq.push_back('{ref_mem[4], cyc + 1});
            end
        end
        tick();
        i_req = 1'b0;
        d_req = 1'b0;
    endtask
`else
    task automatic test_d_priority();
        tick();
        i_req  = 1'b1;
        i_addr = 32'h0000_0008;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h0000_0010;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checks++;
            if (bus !== bus_exp(1'b0, 1'b1, 1'b0, 4'h0, 8'd4)) begin
                errors++;
                $display("FAIL dprio_cycle%0d: got %b, want %b", k, bus, bus_exp(1'b0, 1'b1, 1'b0, 4'h0, 8'd4));
            end
            dq.push_back('{ref_mem[4], cyc + 1});
        end
        tick();
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if (bus !== bus_exp(1'b1, 1'b0, 1'b0, 4'h0, 8'd2)) begin
            errors++;
            $display("FAIL dprio_release: got %b, want %b", bus, bus_exp(1'b1, 1'b0, 1'b0, 4'h0, 8'd2));
        end
        iq.push_back('{ref_mem[2], cyc + 1});
        tick();
        i_req = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 32'h0;
            ref_mem[i] = 32'h0;
        end
        ram[2] = 32'h0050_0093;  ref_mem[2] = 32'h0050_0093;
        ram[3] = 32'hCAFE_F00D;  ref_mem[3] = 32'hCAFE_F00D;
        ram[4] = 32'h1122_3344;  ref_mem[4] = 32'h1122_3344;
        ram[5] = 32'h55AA_55AA;  ref_mem[5] = 32'h55AA_55AA;
        ram[6] = 32'h0BAD_F00D;  ref_mem[6] = 32'h0BAD_F00D;

        test_reset();
        test_fetch();
        test_collision();
        test_store_load();
        test_flush();
        test_reset_mid();
        test_back_to_back();
`ifdef MEM_ARB_STARVE_GUARD_EN
        test_starve();
`else
        test_d_priority();
`endif
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (iq.size() != 0 || dq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d fetch and %0d load responses never arrived, want 0 and 0", iq.size(), dq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port synchronous RAM between the instruction-fetch port (I) and the load/store port (D) of the RV32I core.
- Accepts at most one access per cycle; the RAM has a 1-cycle read latency, so any access can be issued every cycle.
- Routes each read response back to its owner and squashes stale fetches on a redirect.
- Replaces the separate imem/dmem arrays once the unified memory lands.

Parameters:
- ADDR_W, 8: word-address width to the RAM (256 words); byte address bits [ADDR_W+1:2] are used, the rest are ignored.
- STARVE_LIMIT, 4: consecutive denied I cycles before I is forced ahead of D (optional feature only).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; I holds i_req/i_addr stable until i_gnt.
- i_addr  in  32  fetch byte address.
- i_gnt  out  1  fetch accepted this cycle (combinational).
- i_rvalid  out  1  fetch data valid (registered).
- i_rdata  out  32  fetch data; equals mem_rdata while i_rvalid.
- i_flush  in  1  redirect; squash fetches.
- d_req  in  1  data request; D holds its inputs stable until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data.
- d_wstrb  in  4  store byte enables.
- d_gnt  out  1  data access accepted (combinational).
- d_rvalid  out  1  load data valid (registered; loads only).
- d_rdata  out  32  load data; equals mem_rdata while d_rvalid.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write.
- mem_addr  out  ADDR_W  RAM word address.
- mem_wdata  out  32  RAM write data.
- mem_wstrb  out  4  RAM byte enables.
- mem_rdata  in  32  RAM read data, valid 1 cycle after mem_en with mem_we = 0.

Behaviour:
- Reset (asynchronous, active-high) forces, immediately and for as long as reset is high:
  - all grants 0, mem_en 0, i_rvalid 0, d_rvalid 0;
  - pend = IDLE, starve count = 0.
- Reset mid-operation discards any in-flight response; no rvalid fires for it after reset is released.
- Priority is fixed: D over I, because a pending load/store belongs to an already-fetched instruction.
- Grant rules:
  - d_gnt = d_req & ~reset.
  - i_gnt = i_req & ~d_req & ~i_flush & ~reset.
  - While i_flush = 1 no fetch is granted.
- Memory drive:
  - mem_en = i_gnt | d_gnt.
  - mem_addr, mem_we, mem_wdata, mem_wstrb come from the granted port; for I, mem_we = 0 and mem_wstrb = 0.
  - When nothing is granted, mem_* outputs are 0.
- Response FSM (pend register), states IDLE, I_PEND, D_PEND, next state each edge:
  - I_PEND if i_gnt;
  - D_PEND if (d_gnt & ~d_we);
  - otherwise IDLE.
  - Stores never enter D_PEND.
- Outputs derived from pend:
  - i_rvalid = (pend == I_PEND) & ~i_flush.
  - d_rvalid = (pend == D_PEND).
  - Read-data buses pass mem_rdata unchanged while their rvalid is high and are 0 otherwise.
- Latency: grant in cycle N leads to rvalid in cycle N+1. Back-to-back grants give back-to-back responses, one per cycle, in grant order.
- Simultaneous i_req and d_req: D is granted; I is held off and retried the next cycle.
- i_flush in the same cycle as a due I response: that response is suppressed (i_rvalid = 0) and no new fetch is granted that cycle.
- Store followed by a load to the same address in the next cycle returns the new data (RAM write-first behaviour is the RAM's contract, not the arbiter's).
- Address wrap: byte addresses beyond 4*2^ADDR_W alias modulo the RAM size; no error is raised.

Optional Feature:
- Macro MEM_ARB_STARVE_GUARD_EN.
- With the macro defined:
  - A counter increments each cycle in which i_req = 1 and i_gnt = 0 (flush cycles excluded), and clears on i_gnt.
  - Once the count reaches STARVE_LIMIT, I wins over D for exactly one grant; d_gnt = 0 in that cycle and D retries.
  - The counter saturates at STARVE_LIMIT.
- Without the macro: no counter exists and D always wins.

Decomposition:
- Package mem_arb_pkg holds:
  - the pend state encoding (IDLE = 2'd0, I_PEND = 2'd1, D_PEND = 2'd2);
  - the default ADDR_W and STARVE_LIMIT;
  - a port-ID enum shared with the core's LSU.
- One sub-module is natural: mem_arb_starve_ctr, the saturating counter and its force flag, instantiated only under MEM_ARB_STARVE_GUARD_EN.

Test Plan:
- Fetch at 0x00000008, RAM word 2 = 0x00500093 → i_gnt in cycle N, mem_addr = 2; i_rvalid = 1 and i_rdata = 0x00500093 in N+1.
- i_req and d_req (load, 0x10) asserted together → d_gnt in N, i_gnt in N+1; d_rvalid in N+1, i_rvalid in N+2.
- Store 0xDEADBEEF with wstrb 4'b0011 to 0x20, then load 0x20 → store gets no d_rvalid; the load returns 0x0000BEEF given a zeroed RAM.
- Fetch granted in N, i_flush = 1 in N+1 → i_rvalid stays 0 and i_gnt = 0 in N+1.
- Reset asserted in the cycle after a load grant → d_rvalid stays 0 and mem_en drops immediately; after release the FSM is IDLE.
- With MEM_ARB_STARVE_GUARD_EN, STARVE_LIMIT = 4, d_req and i_req held high → four D grants, then one I grant, then D again.
